// File: rtl/cordic_req_arbiter.sv
// Two-requester arbiter/sequencer in front of the shared CORDIC core, with an in-order tag FIFO for result routing.
// Define CORDIC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); the default build is round-robin.
module cordic_req_arbiter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic [31:0] in_interface,
    output logic        valid_in_interface,
    input  logic [31:0] out_interface,
    input  logic        valid_out_interface,
    output logic        busy,
    output logic        err_orphan
);
    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0] count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             tag_mem [DEPTH];
    logic             issue_ok;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;
    logic             orphan;
    logic             head_tag;

    // A request transfers on a cycle where reqN_valid && reqN_ready; ready is raised only for the
    // arbitration winner while a slot is free, so ready and the handshake are the same signal.
    assign issue_ok = (count < CNT_W'(DEPTH));

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    assign grant0 = issue_ok && req0_valid;
    assign grant1 = issue_ok && req1_valid && !req0_valid;
`else
    logic last;
    assign grant0 = issue_ok && req0_valid && (!req1_valid || last);
    assign grant1 = issue_ok && req1_valid && (!req0_valid || !last);
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign push       = grant0 || grant1;
    // The counter equals FIFO occupancy, so it doubles as the empty check.
    assign pop        = valid_out_interface && (count != '0);
    assign orphan     = valid_out_interface && (count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            count              <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            in_interface       <= '0;
            valid_in_interface <= 1'b0;
            rsp0_valid         <= 1'b0;
            rsp0_data          <= '0;
            rsp1_valid         <= 1'b0;
            rsp1_data          <= '0;
            busy               <= 1'b0;
            err_orphan         <= 1'b0;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
            last               <= 1'b1;
`endif
        end else begin
            valid_in_interface <= push;
            if (push) begin
                in_interface <= grant1 ? req1_data : req0_data;
                wr_ptr       <= wr_ptr + 1'b1;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
                last         <= grant1;
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rsp0_valid <= pop && !head_tag;
            rsp1_valid <= pop && head_tag;
            if (pop && !head_tag) begin
                rsp0_data <= out_interface;
            end
            if (pop && head_tag) begin
                rsp1_data <= out_interface;
            end
            if (orphan) begin
                err_orphan <= 1'b1;
            end
            busy <= (count != '0);
        end
    end
endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Bench for cordic_req_arbiter: a vector table for issue/contention/return, then full, wrap and orphan sequences.
module tb_cordic_req_arbiter;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_data = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_data = '0;
    logic        req1_ready;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic [31:0] in_interface;
    logic        valid_in_interface;
    logic [31:0] out_interface = '0;
    logic        valid_out_interface = 1'b0;
    logic        busy;
    logic        err_orphan;

    cordic_req_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .in_interface(in_interface), .valid_in_interface(valid_in_interface),
        .out_interface(out_interface), .valid_out_interface(valid_out_interface),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 HCLK = ~HCLK;

    int n_vec  = 0;
    int n_fail = 0;
    logic mon_en = 1'b0;
    logic        tag_q[$];
    logic [32:0] exp_q[$];

    typedef struct {
        logic rst_n; logic v0; logic [31:0] d0; logic v1; logic [31:0] d1; logic cv; logic [31:0] cd;
        logic e_rdy0; logic e_rdy1; logic e_vin; logic [31:0] e_in;
        logic e_r0v; logic [31:0] e_r0d; logic e_r1v; logic [31:0] e_r1d; logic e_busy; logic e_err;
    } vec_t;
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; results are matched to issued tags before this cycle's issue is recorded.
    task automatic drive(input logic rst, input logic v0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] d1, input logic cv, input logic [31:0] cd);
        @(negedge HCLK);
        HRESETn = rst; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        valid_out_interface = cv; out_interface = cd;
        #1;
        if (!rst) begin
            tag_q.delete();
            exp_q.delete();
        end else begin
            if (cv && tag_q.size() > 0) exp_q.push_back({tag_q.pop_front(), cd});
            if (req0_ready && req0_valid) tag_q.push_back(1'b0);
            if (req1_ready && req1_valid) tag_q.push_back(1'b1);
        end
    endtask

    always @(negedge HCLK) begin
        if (mon_en && (rsp0_valid || rsp1_valid)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp0_valid=%b rsp1_valid=%b expected none", rsp0_valid, rsp1_valid);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_both", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
                check("rsp_port", {31'b0, rsp1_valid}, {31'b0, e[32]});
                check("rsp_data", e[32] ? rsp1_data : rsp0_data, e[31:0]);
            end
        end
    end

    task automatic build_table();
        logic g [6];
        logic [31:0] gd [6];
        logic [31:0] h0, h1;
        vecs[0] = '{1, 1, 32'h1234, 0, 0, 0, 0,          1, 0, 0, 0,          0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 0,                 0, 0, 1, 32'h1234,   0, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 0, 0, 1, 32'hABCD,          0, 0, 0, 32'h1234,   0, 0, 0, 0, 1, 0};
        vecs[3] = '{1, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 32'h1234,   1, 32'hABCD, 0, 0, 1, 0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 32'h1234,   0, 32'hABCD, 0, 0, 0, 0};
        for (int c = 0; c < 6; c++) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
            g[c] = 1'b0;
`else
            g[c] = c[0];
`endif
            gd[c] = g[c] ? 32'h200 + c : 32'h100 + c;
        end
        for (int c = 0; c < 6; c++) begin
            vecs[5 + c] = '{1, 1, 32'h100 + c, 1, 32'h200 + c, 0, 0,
                            !g[c], g[c], c > 0, (c > 0) ? gd[c - 1] : 32'h0,
                            0, 0, 0, 0, c >= 2, 0};
        end
        h0 = 0;
        h1 = 0;
        for (int k = 0; k < 7; k++) begin
            logic rv0, rv1;
            rv0 = (k > 0) && !g[k - 1];
            rv1 = (k > 0) && g[k - 1];
            if (rv0) h0 = 32'hC0 + k - 1;
            if (rv1) h1 = 32'hC0 + k - 1;
            vecs[11 + k] = '{1, 0, 0, 0, 0, k < 6, (k < 6) ? 32'hC0 + k : 32'h0,
                             0, 0, k == 0, gd[5], rv0, h0, rv1, h1, 1, 0};
        end
        vecs[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, gd[5], 0, h0, 0, h1, 0, 0};
    endtask

    initial begin
        int grants;
        build_table();
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst_n, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].cv, vecs[i].cd);
            check($sformatf("v%0d_rdy0", i), {31'b0, req0_ready}, {31'b0, vecs[i].e_rdy0});
            check($sformatf("v%0d_rdy1", i), {31'b0, req1_ready}, {31'b0, vecs[i].e_rdy1});
            check($sformatf("v%0d_vin", i), {31'b0, valid_in_interface}, {31'b0, vecs[i].e_vin});
            check($sformatf("v%0d_in", i), in_interface, vecs[i].e_in);
            check($sformatf("v%0d_rsp0v", i), {31'b0, rsp0_valid}, {31'b0, vecs[i].e_r0v});
            check($sformatf("v%0d_rsp0d", i), rsp0_data, vecs[i].e_r0d);
            check($sformatf("v%0d_rsp1v", i), {31'b0, rsp1_valid}, {31'b0, vecs[i].e_r1v});
            check($sformatf("v%0d_rsp1d", i), rsp1_data, vecs[i].e_r1d);
            check($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
            check($sformatf("v%0d_err", i), {31'b0, err_orphan}, {31'b0, vecs[i].e_err});
        end

        // Fill to DEPTH with no results, then free one slot.
        drive(0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 32'h300 + i, 1, 32'h400 + i, 0, 0);
            check("full_grant", {31'b0, req0_ready ^ req1_ready}, 32'd1);
        end
        drive(1, 1, 32'h310, 1, 32'h410, 1, 32'hF00);
        check("full_rdy", {30'b0, req0_ready, req1_ready}, 32'd0);
        check("full_busy", {31'b0, busy}, 32'd1);
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h320 + i, 1, 32'h420 + i, 0, 0);
            if (req0_ready || req1_ready) grants++;
        end
        check("full_one_grant", grants, 32'd1);

        // Hold occupancy at DEPTH-1 with a push and a pop every cycle so both pointers wrap.
        drive(1, 0, 0, 0, 0, 1, 32'hF01);
        grants = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 32'h600 + i, 1, 32'h700 + i, 1, 32'h5000 + i);
            if (req0_ready || req1_ready) grants++;
        end
        check("wrap_grants", grants, 32'd40);
        for (int i = 0; i < DEPTH - 1; i++) drive(1, 0, 0, 0, 0, 1, 32'h8000 + i);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("drain_pending", exp_q.size(), 32'd0);
        check("drain_busy", {31'b0, busy}, 32'd0);
        check("drain_err", {31'b0, err_orphan}, 32'd0);

        // Orphan result with nothing outstanding, then reset clears the sticky flag.
        drive(1, 0, 0, 0, 0, 1, 32'hDEAD);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("orph_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
        check("orph_err", {31'b0, err_orphan}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("orph_sticky", {31'b0, err_orphan}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst_err", {31'b0, err_orphan}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_vin", {31'b0, valid_in_interface}, 32'd0);
        check("rst_in", in_interface, 32'd0);
        check("rst_rsp0d", rsp0_data, 32'd0);
        check("rst_rsp1d", rsp1_data, 32'd0);
        check("rst_rspv", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
